// File: rtl/huffman_length_gen_pkg.sv
// Shared types and helpers for the Huffman code-length generator.
// Holds the FSM state enum, default widths, saturating add and field slice.
package huff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIND,
        MERGE,
        SORT,
        DONE
    } state_e;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_TOTAL_SYMBOLS = 10;
    localparam int DEF_ADDR_WIDTH    = 4;
    localparam int DEF_LEN_WIDTH     = 4;
    localparam int DEF_MAXHIGHT      = 10;

    localparam int FIELD_MAX = 1024;

    // a + b clamped to the all-ones value of a w-bit field
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] s;
        logic [32:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (33'd1 << w) - 33'd1;
        if (s > m) s = m;
        return s[31:0];
    endfunction

    // entry idx of a vector packed as consecutive w-bit fields
    function automatic logic [31:0] field(
        input logic [FIELD_MAX-1:0] vec,
        input int                   idx,
        input int                   w
    );
        logic [FIELD_MAX-1:0] m;
        m = (FIELD_MAX'(1) << w) - FIELD_MAX'(1);
        return 32'((vec >> (idx * w)) & m);
    endfunction

endpackage

// File: rtl/huffman_length_gen_if.sv
// Job bus of the Huffman length generator: start pulse, inputs, results.
// master drives ena/ialpha/ifrequency; slave drives the o* result signals.
interface huffman_length_gen_if #(
    parameter int TOTAL_SYMBOLS = 10,
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int LEN_WIDTH     = 4
);
    logic                                ena;
    logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] ialpha;
    logic [DATA_WIDTH*TOTAL_SYMBOLS-1:0] ifrequency;
    logic                                obusy;
    logic                                odone;
    logic [LEN_WIDTH*TOTAL_SYMBOLS-1:0]  olengths;
    logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] oalpha;
    logic                                ooverflow;

    modport master (
        output ena, ialpha, ifrequency,
        input  obusy, odone, olengths, oalpha, ooverflow
    );

    modport slave (
        input  ena, ialpha, ifrequency,
        output obusy, odone, olengths, oalpha, ooverflow
    );
endinterface

// File: rtl/huff_min2_tracker.sv
// Sequential scanner keeping the two smallest (freq, index) pairs seen.
// Ports: clk, rst, clear_i, valid_i, freq_i, index_i -> min1_o, min2_o.
module huff_min2_tracker #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] freq_i,
    input  logic [IDX_WIDTH-1:0]  index_i,
    output logic [IDX_WIDTH-1:0]  min1_o,
    output logic [IDX_WIDTH-1:0]  min2_o
);
    logic [DATA_WIDTH-1:0] f1_q, f1_d, f2_q, f2_d;
    logic [IDX_WIDTH-1:0]  i1_q, i1_d, i2_q, i2_d;
    logic                  h1_q, h1_d, h2_q, h2_d;

    // indices arrive in ascending order, so strict < keeps the lower index on ties
    always_comb begin
        f1_d = f1_q;
        f2_d = f2_q;
        i1_d = i1_q;
        i2_d = i2_q;
        h1_d = h1_q;
        h2_d = h2_q;
        if (clear_i) begin
            h1_d = 1'b0;
            h2_d = 1'b0;
        end else if (valid_i) begin
            if (!h1_q || freq_i < f1_q) begin
                f2_d = f1_q;
                i2_d = i1_q;
                h2_d = h1_q;
                f1_d = freq_i;
                i1_d = index_i;
                h1_d = 1'b1;
            end else if (!h2_q || freq_i < f2_q) begin
                f2_d = freq_i;
                i2_d = index_i;
                h2_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f1_q <= '0;
            f2_q <= '0;
            i1_q <= '0;
            i2_q <= '0;
            h1_q <= 1'b0;
            h2_q <= 1'b0;
        end else begin
            f1_q <= f1_d;
            f2_q <= f2_d;
            i1_q <= i1_d;
            i2_q <= i2_d;
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end

    assign min1_o = i1_q;
    assign min2_o = i2_q;
endmodule

// File: rtl/huffman_length_gen.sv
// Huffman code-length generator: repeated min-pair merge over a freq vector.
// Ports: clk, rst, bus (slave). Macro HUFF_SORT_OUTPUT_EN sorts the output.
module huffman_length_gen
    import huff_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int TOTAL_SYMBOLS = DEF_TOTAL_SYMBOLS,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
    parameter int MAXHIGHT      = DEF_MAXHIGHT
) (
    input logic                 clk,
    input logic                 rst,
    huffman_length_gen_if.slave bus
);
    localparam int N  = TOTAL_SYMBOLS;
    localparam int CW = $clog2(N);
    localparam int KW = $clog2(N + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] freq_q  [N];
    logic [DATA_WIDTH-1:0] freq_d  [N];
    logic [N-1:0]          mask_q  [N];
    logic [N-1:0]          mask_d  [N];
    logic [LEN_WIDTH-1:0]  len_q   [N];
    logic [LEN_WIDTH-1:0]  len_d   [N];
    logic [ADDR_WIDTH-1:0] alpha_q [N];
    logic [ADDR_WIDTH-1:0] alpha_d [N];
    logic [N-1:0]          act_q, act_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [KW-1:0]         nact_q, nact_d;
    logic                  ovf_q, ovf_d;
`ifdef HUFF_SORT_OUTPUT_EN
    logic [CW-1:0]         idx_q   [N];
    logic [CW-1:0]         idx_d   [N];
`endif

    logic [KW-1:0] k_c;
    logic [CW-1:0] sole_c;
    logic [N-1:0]  merged_c;
    logic [CW-1:0] min1, min2;

    huff_min2_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (CW)
    ) u_min2 (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q != FIND),
        .valid_i ((state_q == FIND) && act_q[cnt_q]),
        .freq_i  (freq_q[cnt_q]),
        .index_i (cnt_q),
        .min1_o  (min1),
        .min2_o  (min2)
    );

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        mask_d   = mask_q;
        len_d    = len_q;
        alpha_d  = alpha_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        nact_d   = nact_q;
        ovf_d    = ovf_q;
`ifdef HUFF_SORT_OUTPUT_EN
        idx_d    = idx_q;
`endif
        k_c      = '0;
        sole_c   = '0;
        merged_c = '0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.ena) begin
                    for (int i = 0; i < N; i++) begin
                        freq_d[i] = DATA_WIDTH'(field(
                            FIELD_MAX'(bus.ifrequency), i, DATA_WIDTH));
                        alpha_d[i] = ADDR_WIDTH'(field(
                            FIELD_MAX'(bus.ialpha), i, ADDR_WIDTH));
                    end
                    ovf_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int i = 0; i < N; i++) begin
                    act_d[i]  = (freq_q[i] != '0);
                    mask_d[i] = N'(1) << i;
                    len_d[i]  = '0;
`ifdef HUFF_SORT_OUTPUT_EN
                    idx_d[i]  = CW'(i);
`endif
                    if (freq_q[i] != '0) begin
                        k_c    = k_c + KW'(1);
                        sole_c = CW'(i);
                    end
                end
                nact_d = k_c;
                cnt_d  = '0;
                if (k_c == KW'(1)) begin
`ifdef HUFF_SORT_OUTPUT_EN
                    // lone symbol sorts last; the zero-length rest keep their order
                    len_d[N-1] = LEN_WIDTH'(1);
                    for (int p = 0; p < N; p++) begin
                        if (p == N - 1)
                            idx_d[p] = sole_c;
                        else if (CW'(p) < sole_c)
                            idx_d[p] = CW'(p);
                        else
                            idx_d[p] = CW'(p + 1);
                    end
`else
                    len_d[sole_c] = LEN_WIDTH'(1);
`endif
                end
                state_d = (k_c <= KW'(1)) ? DONE : FIND;
            end
            FIND: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                // the merged node lives on in min1's slot
                merged_c     = mask_q[min1] | mask_q[min2];
                freq_d[min1] = DATA_WIDTH'(sat_add(32'(freq_q[min1]),
                                                   32'(freq_q[min2]),
                                                   DATA_WIDTH));
                mask_d[min1] = merged_c;
                act_d[min2]  = 1'b0;
                for (int s = 0; s < N; s++) begin
                    if (merged_c[s]) begin
                        len_d[s] = LEN_WIDTH'(sat_add(32'(len_q[s]), 32'd1,
                                                      LEN_WIDTH));
                        if (int'(len_q[s]) + 1 > MAXHIGHT) ovf_d = 1'b1;
                    end
                end
                nact_d = nact_q - KW'(1);
                if (nact_q == KW'(2)) begin
`ifdef HUFF_SORT_OUTPUT_EN
                    state_d = SORT;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = FIND;
                end
            end
            SORT: begin
`ifdef HUFF_SORT_OUTPUT_EN
                // odd-even transposition; pairs of one phase are disjoint
                for (int i = 0; i < N - 1; i++) begin
                    if ((i % 2) == int'(cnt_q[0])) begin
                        if (len_q[i] > len_q[i+1] ||
                            (len_q[i] == len_q[i+1] &&
                             idx_q[i] > idx_q[i+1])) begin
                            len_d[i]   = len_q[i+1];
                            len_d[i+1] = len_q[i];
                            idx_d[i]   = idx_q[i+1];
                            idx_d[i+1] = idx_q[i];
                        end
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            freq_q  <= '{default: '0};
            mask_q  <= '{default: '0};
            len_q   <= '{default: '0};
            alpha_q <= '{default: '0};
            act_q   <= '0;
            cnt_q   <= '0;
            nact_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef HUFF_SORT_OUTPUT_EN
            idx_q   <= '{default: '0};
`endif
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            alpha_q <= alpha_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            nact_q  <= nact_d;
            ovf_q   <= ovf_d;
`ifdef HUFF_SORT_OUTPUT_EN
            idx_q   <= idx_d;
`endif
        end
    end

    always_comb begin
        bus.olengths = '0;
        bus.oalpha   = '0;
        for (int i = 0; i < N; i++) begin
            bus.olengths[LEN_WIDTH*i +: LEN_WIDTH] = len_q[i];
`ifdef HUFF_SORT_OUTPUT_EN
            bus.oalpha[ADDR_WIDTH*i +: ADDR_WIDTH] = alpha_q[idx_q[i]];
`else
            bus.oalpha[ADDR_WIDTH*i +: ADDR_WIDTH] = alpha_q[i];
`endif
        end
    end

    assign bus.obusy     = (state_q != IDLE) && (state_q != DONE);
    assign bus.odone     = (state_q == DONE);
    assign bus.ooverflow = ovf_q;
endmodule

// File: tb/tb_huffman_length_gen.sv
// Self-checking bench for huffman_length_gen (N=6, MAXHIGHT=4).
// Directed and random jobs compared against a merge-list reference model.
module tb_huffman_length_gen;
    localparam int N  = 6;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int LW = 4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    huffman_length_gen_if #(
        .TOTAL_SYMBOLS (N),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .LEN_WIDTH     (LW)
    ) bus ();

    huffman_length_gen #(
        .DATA_WIDTH    (DW),
        .TOTAL_SYMBOLS (N),
        .ADDR_WIDTH    (AW),
        .LEN_WIDTH     (LW),
        .MAXHIGHT      (MH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   cur_f [N];
    logic [AW-1:0]   cur_a [N];
    logic [N*LW-1:0] exp_len;
    logic [N*AW-1:0] exp_alpha;
    logic            exp_ovf;
    int              exp_lat;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list of live nodes, each a weight plus a member set.
    task automatic model();
        int w [N];
        bit alive [N];
        bit mem [N][N];
        int len [N];
        int ord [N];
        int k, live, a, b, t, j;
        k = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            w[i] = int'(cur_f[i]);
            alive[i] = (w[i] != 0);
            len[i] = 0;
            ord[i] = i;
            for (int m = 0; m < N; m++) mem[i][m] = (i == m);
            if (alive[i]) k++;
        end
        if (k == 1)
            for (int i = 0; i < N; i++) if (alive[i]) len[i] = 1;
        live = k;
        while (live > 1) begin
            a = -1;
            for (int i = 0; i < N; i++)
                if (alive[i] && (a < 0 || w[i] < w[a])) a = i;
            b = -1;
            for (int i = 0; i < N; i++)
                if (alive[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
            w[a] = (w[a] + w[b] > 65535) ? 65535 : w[a] + w[b];
            alive[b] = 1'b0;
            live--;
            for (int s = 0; s < N; s++) begin
                mem[a][s] = mem[a][s] | mem[b][s];
                if (mem[a][s]) begin
                    if (len[s] + 1 > MH) exp_ovf = 1'b1;
                    len[s] = (len[s] + 1 > 15) ? 15 : len[s] + 1;
                end
            end
        end
`ifdef HUFF_SORT_OUTPUT_EN
        for (int i = 1; i < N; i++) begin
            t = ord[i];
            j = i - 1;
            while (j >= 0 && len[ord[j]] > len[t]) begin
                ord[j+1] = ord[j];
                j--;
            end
            ord[j+1] = t;
        end
`endif
        for (int p = 0; p < N; p++) begin
            exp_len[LW*p +: LW]   = LW'(len[ord[p]]);
            exp_alpha[AW*p +: AW] = cur_a[ord[p]];
        end
        if (k <= 1) exp_lat = 2;
        else exp_lat = 2 + (k - 1) * (N + 1);
`ifdef HUFF_SORT_OUTPUT_EN
        if (k >= 2) exp_lat = exp_lat + N;
`endif
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            bus.ialpha[AW*i +: AW]     = cur_a[i];
            bus.ifrequency[DW*i +: DW] = cur_f[i];
        end
    endtask

    task automatic run_job(input string tag, input bit mid_ena);
        int cyc;
        model();
        drive_inputs();
        bus.ena = 1'b1;
        @(posedge clk); #1;
        bus.ena = 1'b0;
        check({tag, "_busy_start"}, 64'(bus.obusy), 64'(1));
        check({tag, "_done_low"}, 64'(bus.odone), 64'(0));
        cyc = 1;
        while (bus.odone !== 1'b1 && cyc < 500) begin
            bus.ena = (mid_ena && cyc == 10);
            if (cyc == 3) begin
                bus.ifrequency = (N*DW)'({$urandom, $urandom, $urandom});
                bus.ialpha     = (N*AW)'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.ena = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_len"}, 64'(bus.olengths), 64'(exp_len));
        check({tag, "_alpha"}, 64'(bus.oalpha), 64'(exp_alpha));
        check({tag, "_ovf"}, 64'(bus.ooverflow), 64'(exp_ovf));
        check({tag, "_busy_end"}, 64'(bus.obusy), 64'(0));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check({tag, "_hold_done"}, 64'(bus.odone), 64'(1));
        check({tag, "_hold_len"}, 64'(bus.olengths), 64'(exp_len));
        check({tag, "_hold_alpha"}, 64'(bus.oalpha), 64'(exp_alpha));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.ialpha = '0;
        bus.ifrequency = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.obusy), 64'(0));
        check("rst_done", 64'(bus.odone), 64'(0));
        check("rst_ovf", 64'(bus.ooverflow), 64'(0));
        check("rst_len", 64'(bus.olengths), 64'(0));
        check("rst_alpha", 64'(bus.oalpha), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        cur_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        cur_f = '{16'd5, 16'd9, 16'd12, 16'd13, 16'd16, 16'd45};
        run_job("A", 1'b0);
`ifndef HUFF_SORT_OUTPUT_EN
        check("A_const_len", 64'(bus.olengths), 64'(24'h133344));
        check("A_const_lat", 64'(exp_lat), 64'(37));
`endif

        cur_a = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        cur_f = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
        run_job("B", 1'b0);
`ifndef HUFF_SORT_OUTPUT_EN
        check("B_const_len", 64'(bus.olengths), 64'(24'h123455));
`endif
        check("B_const_ovf", 64'(bus.ooverflow), 64'(1));

        cur_f = '{16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0};
        run_job("C", 1'b0);
`ifndef HUFF_SORT_OUTPUT_EN
        check("C_const_len", 64'(bus.olengths), 64'(24'h000100));
`endif

        cur_f = '{default: 16'd0};
        run_job("D", 1'b0);
        check("D_const_len", 64'(bus.olengths), 64'(0));

        cur_f = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd0, 16'd0};
        run_job("E", 1'b1);
`ifndef HUFF_SORT_OUTPUT_EN
        check("E_const_len", 64'(bus.olengths), 64'(24'h002222));
`endif

        // reset in the second FIND round, after lengths became nonzero
        cur_a = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};
        cur_f = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60};
        drive_inputs();
        bus.ena = 1'b1;
        @(posedge clk); #1;
        bus.ena = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 64'(bus.obusy), 64'(0));
        check("midrst_done", 64'(bus.odone), 64'(0));
        check("midrst_ovf", 64'(bus.ooverflow), 64'(0));
        check("midrst_len", 64'(bus.olengths), 64'(0));
        check("midrst_alpha", 64'(bus.oalpha), 64'(0));
        run_job("F", 1'b0);
        run_job("G_b2b", 1'b0);

`ifdef HUFF_SORT_OUTPUT_EN
        cur_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        cur_f = '{16'd45, 16'd5, 16'd16, 16'd9, 16'd13, 16'd12};
        run_job("S", 1'b0);
        check("S_const_len", 64'(bus.olengths), 64'(24'h443331));
        check("S_const_alpha", 64'(bus.oalpha), 64'(24'h315420));
`endif

        for (int t = 0; t < 24; t++) begin
            int r;
            for (int i = 0; i < N; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 2) cur_f[i] = '0;
                else if (r < 4) cur_f[i] = DW'($urandom_range(65000, 65535));
                else cur_f[i] = DW'($urandom_range(1, 100));
                cur_a[i] = AW'($urandom);
            end
            run_job($sformatf("R%0d", t), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
